// File: rtl/video_line_capture.sv
// video_line_capture: AXI4-Stream video slave that unpacks 24-bit RGB pixels
// (four pixels per three 32-bit beats), thresholds each pixel's red channel
// to one cell bit and writes each assembled row to a line-wide BRAM port.
module video_line_capture #(
    parameter int unsigned X_SIZE          = 1280,
    parameter int unsigned Y_SIZE          = 720,
    parameter logic [7:0]  ALIVE_THRESHOLD = 8'h80
) (
    input  logic                      in_stream_aclk,
    input  logic                      periph_reset,
    input  logic [31:0]               in_stream_tdata,
    input  logic [3:0]                in_stream_tkeep,
    input  logic                      in_stream_tlast,
    input  logic                      in_stream_tuser,
    input  logic                      in_stream_tvalid,
    output logic                      in_stream_tready,
    input  logic                      capture_en,
    input  logic                      err_clr,
    output logic                      line_we,
    output logic [$clog2(Y_SIZE)-1:0] line_addr,
    output logic [X_SIZE-1:0]         line_data,
    output logic                      frame_done,
    output logic                      busy,
    output logic                      sync_err
);

    localparam int unsigned X_WIDTH = $clog2(X_SIZE);
    localparam int unsigned Y_WIDTH = $clog2(Y_SIZE);
    localparam int unsigned BEATS   = 3 * X_SIZE / 4;

    // A row never has more beats than pixels, so X_WIDTH covers the beat index.
    localparam logic [X_WIDTH-1:0] LAST_BEAT = X_WIDTH'(BEATS - 1);
    localparam logic [Y_WIDTH-1:0] LAST_ROW  = Y_WIDTH'(Y_SIZE - 1);

    typedef enum logic [1:0] {
        WAIT_SOF,
        CAPTURE,
        WRITE
    } state_t;

    state_t             state, state_next;
    logic [X_WIDTH-1:0] beat_cnt, beat_cnt_next;
    logic [1:0]         phase, phase_next;      // beat position inside a 3-beat group
    logic [Y_WIDTH-1:0] row, row_next;
    logic [15:0]        residue, residue_unpk;  // bytes of a pixel split across beats
    logic [X_SIZE-1:0]  line_sr;                // row being assembled, pixel 0 ends at MSB
    logic [X_SIZE-1:0]  shifted;

    logic        beat_fire;
    logic        sof_beat;   // this beat starts row 0 of a new frame
    logic [1:0]  eff_phase;
    logic [23:0] pix_a, pix_b;
    logic        two_cells;
    logic        cell_a, cell_b;
    logic        take, load_out, err_set;

    // Ready only while accepting beats; forced low while reset is held.
    assign in_stream_tready = (state == WAIT_SOF || state == CAPTURE) && !periph_reset;
    assign beat_fire        = in_stream_tvalid && in_stream_tready;

    // A start-of-frame beat restarts at row 0 beat 0, except when it already is beat 0 of row 0.
    assign sof_beat = beat_fire && in_stream_tuser &&
                      ((state == WAIT_SOF && capture_en) ||
                       (state == CAPTURE && (beat_cnt != '0 || row != '0)));

    // A restarting beat is always unpacked as the first beat of a group.
    assign eff_phase = sof_beat ? 2'd0 : phase;

    // Unpack the pixels completed by this beat and the bytes left over for the next one.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        pix_a        = '0;
        pix_b        = '0;
        two_cells    = 1'b0;
        residue_unpk = residue;
        case (eff_phase)
            2'd0: begin
                pix_a        = in_stream_tdata[23:0];
                residue_unpk = {8'h00, in_stream_tdata[31:24]};
            end
            2'd1: begin
                pix_a        = {in_stream_tdata[15:0], residue[7:0]};
                residue_unpk = in_stream_tdata[31:16];
            end
            default: begin
                pix_a     = {in_stream_tdata[7:0], residue};
                pix_b     = in_stream_tdata[31:8];
                two_cells = 1'b1;
            end
        endcase
    end

    assign cell_a  = (pix_a[23:16] >= ALIVE_THRESHOLD);
    assign cell_b  = (pix_b[23:16] >= ALIVE_THRESHOLD);
    assign shifted = two_cells ? {line_sr[X_SIZE-3:0], cell_a, cell_b}
                               : {line_sr[X_SIZE-2:0], cell_a};

    // Green/blue channels and tkeep carry no information for the cell grid.
    logic unused_bits;
    assign unused_bits = ^{in_stream_tkeep, pix_a[15:0], pix_b[15:0]};

    // Next-state logic: framing, beat/row counters and error detection.
    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        phase_next    = phase;
        row_next      = row;
        take          = 1'b0;
        load_out      = 1'b0;
        err_set       = 1'b0;
        case (state)
            WAIT_SOF: begin
                if (sof_beat) begin
                    state_next    = CAPTURE;
                    row_next      = '0;
                    beat_cnt_next = X_WIDTH'(1);
                    phase_next    = 2'd1;
                    take          = 1'b1;
                end
            end
            CAPTURE: begin
                if (sof_beat) begin
                    // Unexpected start of frame: drop the partial row and resync to row 0.
                    err_set       = 1'b1;
                    row_next      = '0;
                    beat_cnt_next = X_WIDTH'(1);
                    phase_next    = 2'd1;
                    take          = 1'b1;
                end else if (beat_fire && beat_cnt == LAST_BEAT) begin
                    err_set       = !in_stream_tlast;
                    take          = 1'b1;
                    load_out      = 1'b1;
                    beat_cnt_next = '0;
                    phase_next    = 2'd0;
                    state_next    = WRITE;
                end else if (beat_fire && in_stream_tlast) begin
                    // Early end of line: discard and restart the same row.
                    err_set       = 1'b1;
                    beat_cnt_next = '0;
                    phase_next    = 2'd0;
                end else if (beat_fire) begin
                    take          = 1'b1;
                    beat_cnt_next = beat_cnt + 1'b1;
                    phase_next    = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                end
            end
            WRITE: begin
                if (row == LAST_ROW) begin
                    row_next   = '0;
                    state_next = WAIT_SOF;
                end else begin
                    row_next   = row + 1'b1;
                    state_next = CAPTURE;
                end
            end
            default: state_next = WAIT_SOF;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge in_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            state    <= WAIT_SOF;
            beat_cnt <= '0;
            phase    <= 2'd0;
            row      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_next;
            beat_cnt <= beat_cnt_next;
            phase    <= phase_next;
            row      <= row_next;
        end
    end

    // Row assembly and output hold registers; line_data/line_addr change only on a row write.
    always_ff @(posedge in_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            // NOTE: these wide vectors are flip-flops, not RAM, so they can take a reset value.
            line_sr   <= '0;
            residue   <= '0;
            line_data <= '0;
            line_addr <= '0;
        end else begin
            if (take) begin
                line_sr <= shifted;
                residue <= residue_unpk;
            end
            if (load_out) begin
                line_data <= shifted;
                line_addr <= row;
            end
        end
    end

    // Sticky framing error; a new error wins over a simultaneous clear.
    always_ff @(posedge in_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            sync_err <= 1'b0;
        end else if (err_set) begin
            sync_err <= 1'b1;
        end else if (err_clr) begin
            sync_err <= 1'b0;
        end
    end

    assign line_we    = (state == WRITE);
    assign frame_done = (state == WRITE) && (row == LAST_ROW);
    assign busy       = (state == CAPTURE) || (state == WRITE);

endmodule
